// File: rtl/freq_generator.sv
// freq_generator: programmable square-wave source with double-buffered period/high settings.
module freq_generator #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] period_in,
  input  logic [W-1:0] high_in,
  output logic         signal_out,
  output logic         period_tick,
  output logic         pending,
  output logic         err,
  output logic         active
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [W-1:0] period_sh, high_sh, period_a, high_a, cnt;
  logic cfg_valid, ok, at_end, xfer;
  assign ok     = period_in >= W'(2) && high_in != '0 && high_in < period_in;
  assign at_end = active && cnt == period_a - W'(1);
  // DRAIN never transfers, so a pending setting waits for IDLE or the next RUN boundary
  assign xfer   = pending && (state == IDLE || (state == RUN && at_end));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (enable && (cfg_valid || pending)) ? RUN : IDLE;
      RUN:     state_nx = enable ? RUN : (at_end ? IDLE : DRAIN);
      DRAIN:   state_nx = at_end ? (enable ? RUN : IDLE) : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_comb active = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      period_sh   <= '0;
      high_sh     <= '0;
      pending     <= 1'b0;
      period_a    <= '0;
      high_a      <= '0;
      cfg_valid   <= 1'b0;
      cnt         <= '0;
      signal_out  <= 1'b0;
      period_tick <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (load && ok) begin
        period_sh <= period_in;
        high_sh   <= high_in;
      end
      pending <= (load && ok) || (pending && !xfer);
      if (xfer) begin
        period_a  <= period_sh;
        high_a    <= high_sh;
        cfg_valid <= 1'b1;
      end
      cnt         <= (!active || at_end) ? '0 : cnt + W'(1);
      signal_out  <= active && cnt < high_a;
      period_tick <= at_end;
      err         <= load && !ok;
    end
endmodule

// File: tb/tb_freq_generator.sv
// tb_freq_generator: scoreboard bench for freq_generator waveforms, reload timing, errors and reset.
module tb_freq_generator;
  localparam int W = 28;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, load = 1'b0;
  logic [W-1:0] period_in = '0, high_in = '0;
  logic signal_out, period_tick, pending, err, active;
  typedef struct packed {logic sig; logic tick; logic pend; logic act; logic err;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, rises = 0;

  freq_generator #(.W(W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .period_in(period_in),
    .high_in(high_in), .signal_out(signal_out), .period_tick(period_tick),
    .pending(pending), .err(err), .active(active)
  );

  always #5 clk = ~clk;

  task automatic push(input logic s, input logic t, input logic p, input logic a, input logic e);
    exp_t x;
    x.sig = s; x.tick = t; x.pend = p; x.act = a; x.err = e;
    q.push_back(x);
  endtask

  task automatic push_per(input int p, input int h, input logic pend);
    for (int j = 0; j < p; j++) push(j < h, j == p - 1, pend, 1'b1, 1'b0);
  endtask

  task automatic run_chk(input int n, input string name);
    exp_t e;
    logic prev;
    for (int i = 0; i < n; i++) begin
      prev = signal_out;
      @(posedge clk);
      #1;
      load = 1'b0;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL %s sb_empty at step %0d", name, i);
      end else begin
        e = q.pop_front();
        if ({signal_out, period_tick, pending, active, err} !== e) begin
          errors++;
          $display("FAIL %s step %0d sig/tick/pend/act/err got %b%b%b%b%b want %b", name, i,
                   signal_out, period_tick, pending, active, err, e);
        end
      end
      if (signal_out && !prev) rises++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; load = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic start_run(input int p, input int h);
    do_reset();
    load = 1'b1; period_in = W'(p); high_in = W'(h);
    push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_chk(1, "idle_load");
    enable = 1'b1;
    push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_chk(1, "run_entry");
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; load = 1'b1; period_in = W'(4); high_in = W'(2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({signal_out, period_tick, pending, active, err} !== 5'b0) begin
        errors++;
        $display("FAIL reset outputs got %b want 00000", {signal_out, period_tick, pending, active, err});
      end
    end
    rst = 1'b0; enable = 1'b0; load = 1'b0;
  endtask

  task automatic test_basic();
    start_run(4, 2);
    for (int k = 0; k < 250; k++) push_per(4, 2, 1'b0);
    rises = 0;
    run_chk(1000, "basic_4_2");
    checks++;
    if (rises !== 250) begin
      errors++;
      $display("FAIL basic_edges got %0d want 250", rises);
    end
  endtask

  task automatic test_switch();
    start_run(10, 3);
    for (int j = 0; j < 10; j++) push(j < 3, j == 9, j >= 4 && j <= 8, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) push_per(6, 1, 1'b0);
    run_chk(4, "switch_pre");
    load = 1'b1; period_in = W'(6); high_in = W'(1);
    run_chk(24, "switch_post");
  endtask

  task automatic test_coincide();
    start_run(4, 2);
    for (int j = 0; j < 4; j++) push(j < 2, j == 3, j >= 1, 1'b1, 1'b0);
    for (int j = 0; j < 6; j++) push(j < 2, j == 5, j < 5, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) push_per(8, 3, 1'b0);
    run_chk(1, "coinc_a");
    load = 1'b1; period_in = W'(6); high_in = W'(2);
    run_chk(2, "coinc_b");
    load = 1'b1; period_in = W'(8); high_in = W'(3);
    run_chk(23, "coinc_c");
  endtask

  task automatic test_err();
    start_run(4, 2);
    for (int j = 0; j < 12; j++)
      push((j % 4) < 2, (j % 4) == 3, 1'b0, 1'b1, j == 1 || j == 3 || j == 5);
    run_chk(1, "err_a");
    load = 1'b1; period_in = W'(1); high_in = W'(0);
    run_chk(2, "err_b");
    load = 1'b1; period_in = W'(5); high_in = W'(5);
    run_chk(2, "err_c");
    load = 1'b1; period_in = W'(5); high_in = W'(0);
    run_chk(7, "err_d");
  endtask

  task automatic test_drain();
    start_run(8, 4);
    for (int j = 0; j < 8; j++) push(j < 4, j == 7, 1'b0, j < 7, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_per(8, 4, 1'b0);
    push_per(8, 4, 1'b0);
    run_chk(1, "drain_a");
    enable = 1'b0;
    run_chk(9, "drain_b");
    enable = 1'b1;
    run_chk(2, "drain_c");
    enable = 1'b0;
    run_chk(3, "drain_d");
    enable = 1'b1;
    run_chk(12, "drain_e");
  endtask

  task automatic test_async_rst();
    start_run(8, 4);
    load = 1'b1; period_in = W'(6); high_in = W'(2);
    push(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    run_chk(2, "rst_pre");
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({signal_out, active, pending} !== 3'b000) begin
      errors++;
      $display("FAIL async_rst sig/act/pend got %b want 000", {signal_out, active, pending});
    end
    #1 rst = 1'b0;
    for (int j = 0; j < 10; j++) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_chk(10, "rst_idle");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_switch();
    test_coincide();
    test_err();
    test_drain();
    test_async_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/freq_generator.md
# freq_generator

Programmable square-wave source: the stimulus side of the frequency meter. It produces `signal_out` with a period and high time set in `clk` cycles. New settings are double-buffered so they only take effect on a period boundary, which keeps the output glitch-free. The output drives the frequency counter's `signal_in` on the board and in loop-back tests. It also emits a per-period tick for external pulse accounting.

## Interface
Parameters:
- `W`, 28, width of period/high-time fields and internal counter; max period 2^W-1 cycles.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high; clears every register.
- `enable` in 1: run request; level-sensitive.
- `load` in 1: one-cycle strobe; samples `period_in` / `high_in`.
- `period_in` in W: requested period in `clk` cycles.
- `high_in` in W: requested high time in `clk` cycles.
- `signal_out` out 1: generated square wave; registered.
- `period_tick` out 1: one-cycle pulse on the last cycle of every completed period.
- `pending` out 1: a loaded setting is waiting for the next boundary.
- `err` out 1: one-cycle pulse; the last `load` was rejected.
- `active` out 1: state is RUN or DRAIN.

## Operation
- **Registers**
  - Shadow pair `period_sh`/`high_sh` plus `pending`.
  - Active pair `period_a`/`high_a` plus `cfg_valid`.
  - Cycle counter `cnt` (W bits).
  - State register.
- **Load validation**
  - Accept only if `period_in` ≥ 2 and 1 ≤ `high_in` ≤ `period_in` − 1.
  - Accepted: write the shadow pair and set `pending`=1.
  - Rejected: `err`=1 next cycle; shadow and `pending` unchanged.
  - A second load while pending overwrites the shadow; `pending` stays 1.
- **Transfer (shadow → active)**
  - Occurs when `pending`=1 and either state is IDLE, or state is RUN with `cnt`==`period_a`−1.
  - Transfer sets `cfg_valid`=1 and clears `pending`.
  - If an accepted `load` coincides with a transfer, the transfer uses the pre-load shadow. The new value is written to the shadow and `pending` remains 1.
- **States**
  - IDLE:
    - `cnt`=0 and `signal_out`=0.
    - Goes to RUN when `enable`=1 and (`cfg_valid` or `pending`) after any transfer that cycle.
    - Otherwise stays in IDLE.
  - RUN:
    - `cnt` increments and wraps from `period_a`−1 to 0.
    - If `enable`=0 is sampled before the wrap, go to DRAIN. The current period continues unchanged.
  - DRAIN:
    - Identical counting to RUN, but no transfer.
    - At `cnt`==`period_a`−1: go to IDLE, `cnt`←0.
    - `enable` re-asserted in DRAIN returns to RUN at that same boundary; no gap.
- **Output and tick**
  - `signal_out` is registered: it equals (`cnt` < `high_a`) of the previous cycle while in RUN/DRAIN, and 0 otherwise.
  - `period_tick` is registered and asserts the cycle after `cnt`==`period_a`−1. It pulses for DRAIN's final period too.
- **Counter width**: `cnt` never exceeds `period_a`−1, so no overflow. Comparisons are unsigned W-bit.

## Timing
- **Reset values**
  - All outputs 0.
  - `cnt`=0, shadow and active pairs 0, `cfg_valid`=0, `pending`=0, state IDLE.
  - Reset mid-period forces `signal_out` low asynchronously.
- **Start latency**: `enable` sampled at edge k (configured, IDLE) → RUN at k, `cnt`=0 → `signal_out`=1 from edge k+1.
- **Waveform**: exactly `high_a` cycles high, then `period_a`−`high_a` cycles low. Period is exactly `period_a` cycles.
- **Load to effect**
  - Running: a new setting affects the period starting immediately after the current boundary. The first new-length high phase begins one cycle after the boundary cycle.
  - In IDLE: `load` at edge k transfers at edge k+1.
- **Stop latency**: `enable` low at any point in a period → output stops after that period's last low cycle. `active` drops the cycle after the final boundary.
- `err` and `period_tick` are single-cycle pulses, never stretched.

## Test plan
- Reset, then load period=4/high=2, then enable. Required: `signal_out` 1,1,0,0 repeating from the cycle after RUN entry. `period_tick` fires every 4 cycles. The frequency counter fed by `signal_out` counts 250 edges over 1000 cycles.
- Running at period=10/high=3; load period=6/high=1 at `cnt`=4. Required: `pending`=1 until the boundary, the current 10-cycle period completes intact, then a 1-high/5-low pattern follows with no short or long pulse.
- Load at the same cycle as `cnt`==`period_a`−1 with an earlier setting already pending. Required: the earlier setting is applied, the new one stays pending and applies one period later.
- Loads of (period=1, high=0), (period=5, high=5), (period=5, high=0). Required: `err` pulses once each; shadow, `pending` and waveform unchanged.
- Deassert `enable` at `cnt`=1 of a period=8/high=4 run. Required: the period finishes with 4 high and 4 low cycles, `period_tick` fires, then IDLE with `signal_out`=0. Re-asserting `enable` during DRAIN gives a seamless next period.
- Assert `rst` mid-high-phase. Required: `signal_out`, `active`, `pending` go 0 immediately, `cfg_valid` is cleared, and `enable` alone after release keeps the block in IDLE.
